// File: rtl/ir_packet_receiver.sv
// IR packet receiver: start, car-select and four command marks decoded into COMMAND_OUT; IR_RX_ERRCNT_EN adds an error counter at 0x92.
// Latency: 1 cycle from the synchronized final falling edge; no backpressure (pulses are fire-and-forget, bus data registered).
module ir_packet_receiver #(
  parameter int CLOCK_RATIO    = 1250,
  parameter int START_BURST    = 88,
  parameter int CARSEL_BURST   = 22,
  parameter int GAP            = 40,
  parameter int ASSERT_BURST   = 44,
  parameter int DEASSERT_BURST = 22,
  parameter int TOL            = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IR_IN,
  input  logic [7:0] ADDR_IN,
  input  logic       BUS_RE,
  output logic [7:0] DATA_OUT,
  output logic [3:0] COMMAND_OUT,
  output logic       CMD_VALID,
  output logic       PKT_ERR
);

  localparam int PW = (CLOCK_RATIO > 1) ? $clog2(CLOCK_RATIO) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_RATIO - 1);
  localparam int MARK_MAX  = START_BURST + TOL;
  localparam int SPACE_MAX = GAP + TOL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  logic          ir_s1, ir_s2, ir_d;
  logic          ir_rise, ir_fall, ir_edge;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    width, width_nxt;
  state_t        state;
  logic [2:0]    field;
  logic [3:0]    cmd_sr;
  logic          wait_low;
  logic          new_flag;
  logic          hit1, hit0, mark_ok, space_ok, mark_over, space_over;
  logic          rd_cmd;

  function automatic logic near(input logic [7:0] w, input int len);
    int d;
    d = int'(w) - len;
    return (d >= -TOL) && (d <= TOL);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ir_s1 <= 1'b0;
      ir_s2 <= 1'b0;
      ir_d  <= 1'b0;
    end else begin
      ir_s1 <= IR_IN;
      ir_s2 <= ir_s1;
      ir_d  <= ir_s2;
    end
  end

  assign ir_rise = ir_s2 & ~ir_d;
  assign ir_fall = ~ir_s2 & ir_d;
  assign ir_edge = ir_rise | ir_fall;
  assign tick    = (presc == PRESC_MAX);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc <= '0;
    end else if (ir_edge || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // width_nxt already counts a tick landing in this cycle, so an edge sees the full width
  always_comb begin
    width_nxt = width;
    if (tick && (width != 8'hFF)) begin
      width_nxt = width + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      width <= 8'd0;
    end else if (ir_edge) begin
      width <= 8'd0;
    end else begin
      width <= width_nxt;
    end
  end

  always_comb begin
    hit1 = near(width_nxt, ASSERT_BURST);
    hit0 = near(width_nxt, DEASSERT_BURST);
    case (field)
      3'd0:    mark_ok = near(width_nxt, START_BURST);
      3'd1:    mark_ok = near(width_nxt, CARSEL_BURST);
      default: mark_ok = hit1 ^ hit0;
    endcase
    space_ok   = near(width_nxt, GAP);
    mark_over  = tick && (int'(width_nxt) > MARK_MAX);
    space_over = tick && (int'(width_nxt) > SPACE_MAX);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      field       <= 3'd0;
      cmd_sr      <= 4'd0;
      wait_low    <= 1'b0;
      COMMAND_OUT <= 4'd0;
      CMD_VALID   <= 1'b0;
      PKT_ERR     <= 1'b0;
    end else begin
      CMD_VALID <= 1'b0;
      PKT_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          // an aborted packet may still hold IR high; never re-decode its tail
          if (wait_low) begin
            if (!ir_s2) wait_low <= 1'b0;
          end else if (ir_rise) begin
            state <= MARK;
            field <= 3'd0;
          end
        end
        MARK: begin
          if (ir_fall) begin
            if (!mark_ok) begin
              PKT_ERR  <= 1'b1;
              state    <= IDLE;
              field    <= 3'd0;
              wait_low <= 1'b1;
            end else if (field == 3'd5) begin
              COMMAND_OUT <= {hit1, cmd_sr[3:1]};
              CMD_VALID   <= 1'b1;
              state       <= IDLE;
              field       <= 3'd0;
            end else begin
              if (field >= 3'd2) cmd_sr <= {hit1, cmd_sr[3:1]};
              state <= SPACE;
            end
          end else if (mark_over) begin
            PKT_ERR  <= 1'b1;
            state    <= IDLE;
            field    <= 3'd0;
            wait_low <= 1'b1;
          end
        end
        SPACE: begin
          if (ir_rise) begin
            if (space_ok) begin
              field <= field + 3'd1;
              state <= MARK;
            end else begin
              PKT_ERR  <= 1'b1;
              state    <= IDLE;
              field    <= 3'd0;
              wait_low <= 1'b1;
            end
          end else if (space_over) begin
            PKT_ERR  <= 1'b1;
            state    <= IDLE;
            field    <= 3'd0;
            wait_low <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          field <= 3'd0;
        end
      endcase
    end
  end

  assign rd_cmd = BUS_RE && (ADDR_IN == 8'h91);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      new_flag <= 1'b0;
    end else if (CMD_VALID) begin
      new_flag <= 1'b1;
    end else if (rd_cmd) begin
      new_flag <= 1'b0;
    end
  end

`ifdef IR_RX_ERRCNT_EN
  logic       rd_err;
  logic [3:0] err_cnt;

  assign rd_err = BUS_RE && (ADDR_IN == 8'h92);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_cnt <= 4'd0;
    end else if (rd_err) begin
      err_cnt <= PKT_ERR ? 4'd1 : 4'd0;
    end else if (PKT_ERR && (err_cnt != 4'hF)) begin
      err_cnt <= err_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      DATA_OUT <= 8'h00;
    end else if (rd_cmd) begin
      DATA_OUT <= {new_flag, 3'b000, COMMAND_OUT};
    end else if (rd_err) begin
      DATA_OUT <= {4'h0, err_cnt};
    end else begin
      DATA_OUT <= 8'h00;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (!RST) begin
      DATA_OUT <= 8'h00;
    end else if (rd_cmd) begin
      DATA_OUT <= {new_flag, 3'b000, COMMAND_OUT};
    end else begin
      DATA_OUT <= 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_ir_packet_receiver.sv
// Scoreboarded bench for ir_packet_receiver at CLOCK_RATIO=4: directed packets, aborts, glitch, reset and error counter.
module tb_ir_packet_receiver;
  localparam int CR = 4;

  typedef struct packed {
    logic       err;
    logic [3:0] cmd;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       IR_IN = 1'b0;
  logic [7:0] ADDR_IN = 8'h00;
  logic       BUS_RE = 1'b0;
  logic [7:0] DATA_OUT;
  logic [3:0] COMMAND_OUT;
  logic       CMD_VALID;
  logic       PKT_ERR;

  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];
  logic [3:0] last_cmd = 4'd0;

  always #5 CLK = ~CLK;

  ir_packet_receiver #(.CLOCK_RATIO(CR)) dut (
    .CLK(CLK),
    .RST(RST),
    .IR_IN(IR_IN),
    .ADDR_IN(ADDR_IN),
    .BUS_RE(BUS_RE),
    .DATA_OUT(DATA_OUT),
    .COMMAND_OUT(COMMAND_OUT),
    .CMD_VALID(CMD_VALID),
    .PKT_ERR(PKT_ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every CMD_VALID / PKT_ERR pulse must match the oldest expected event
  always @(negedge CLK) begin
    if (CMD_VALID || PKT_ERR) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, CMD_VALID, PKT_ERR}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", {30'd0, CMD_VALID, PKT_ERR}, e.err ? 32'd1 : 32'd2);
        check("event_cmd", {28'd0, COMMAND_OUT}, {28'd0, e.cmd});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic mark(input int t);
    IR_IN = 1'b1;
    cyc(t * CR);
  endtask

  task automatic space(input int t);
    IR_IN = 1'b0;
    cyc(t * CR);
  endtask

  task automatic push_ev(input logic err, input logic [3:0] cmd);
    ev_t e;
    e.err = err;
    e.cmd = cmd;
    exp_q.push_back(e);
  endtask

  task automatic send_good(input logic [3:0] bits, input int start_len);
    push_ev(1'b0, bits);
    last_cmd = bits;
    mark(start_len);
    space(40);
    mark(22);
    for (int i = 0; i < 4; i++) begin
      space(40);
      mark(bits[i] ? 44 : 22);
    end
    space(10);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    ADDR_IN = a;
    BUS_RE  = 1'b1;
    cyc(1);
    BUS_RE  = 1'b0;
    ADDR_IN = 8'h00;
    d = DATA_OUT;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int err_at;

    // reset state
    cyc(3);
    check("rst_data", {24'd0, DATA_OUT}, 32'h00);
    check("rst_cmd", {28'd0, COMMAND_OUT}, 32'h0);
    check("rst_valid", {31'd0, CMD_VALID}, 32'd0);
    check("rst_err", {31'd0, PKT_ERR}, 32'd0);
    RST = 1'b1;
    cyc(2);
    bus_read(8'h91, rd);
    check("rst_rd91", {24'd0, rd}, 32'h00);
    bus_read(8'h92, rd);
    check("rst_rd92", {24'd0, rd}, 32'h00);

    // nominal packet 0101, then NEW clears on read
    send_good(4'b0101, 88);
    check("pkt1_pending", exp_q.size(), 32'd0);
    check("pkt1_cmd", {28'd0, COMMAND_OUT}, 32'h5);
    bus_read(8'h91, rd);
    check("pkt1_rd_new", {24'd0, rd}, 32'h85);
    bus_read(8'h91, rd);
    check("pkt1_rd_old", {24'd0, rd}, 32'h05);
    cyc(1);
    check("idle_data", {24'd0, DATA_OUT}, 32'h00);

    // start mark at +TOL decodes, one tick more aborts
    send_good(4'b1100, 94);
    check("start94_pending", exp_q.size(), 32'd0);
    push_ev(1'b1, last_cmd);
    mark(95);
    space(20);
    check("start95_pending", exp_q.size(), 32'd0);
    check("start95_hold", {28'd0, COMMAND_OUT}, 32'hC);

    // third space held at 60 ticks: abort at tick 47 of that space
    push_ev(1'b1, last_cmd);
    mark(88);
    space(40);
    mark(22);
    space(40);
    mark(44);
    IR_IN = 1'b0;
    err_at = 0;
    for (int k = 1; k <= 60 * CR; k++) begin
      cyc(1);
      if (PKT_ERR && (err_at == 0)) err_at = k;
    end
    check("space_err_cycle", err_at, 3 + 47 * CR);
    check("space_err_pending", exp_q.size(), 32'd0);
    send_good(4'b1010, 88);
    check("after_space_err_pending", exp_q.size(), 32'd0);
    check("after_space_err_cmd", {28'd0, COMMAND_OUT}, 32'hA);

    // command mark of 33 ticks matches neither bit length
    push_ev(1'b1, last_cmd);
    mark(88);
    space(40);
    mark(22);
    space(40);
    mark(33);
    space(10);
    check("bit33_pending", exp_q.size(), 32'd0);

    // sub-cycle glitch never reaches the synchronizer
    IR_IN = 1'b1;
    #2;
    IR_IN = 1'b0;
    cyc(40);
    check("glitch_pending", exp_q.size(), 32'd0);
    check("glitch_cmd", {28'd0, COMMAND_OUT}, 32'hA);

    // reset in the middle of command bit 2
    mark(88);
    space(40);
    mark(22);
    space(40);
    mark(44);
    space(40);
    mark(22);
    space(40);
    mark(10);
    RST = 1'b0;
    IR_IN = 1'b0;
    cyc(4);
    check("midrst_cmd", {28'd0, COMMAND_OUT}, 32'h0);
    check("midrst_data", {24'd0, DATA_OUT}, 32'h00);
    check("midrst_valid", {31'd0, CMD_VALID}, 32'd0);
    check("midrst_err", {31'd0, PKT_ERR}, 32'd0);
    RST = 1'b1;
    last_cmd = 4'd0;
    cyc(5);
    bus_read(8'h91, rd);
    check("midrst_rd91", {24'd0, rd}, 32'h00);
    send_good(4'b1001, 88);
    check("postrst_pending", exp_q.size(), 32'd0);
    bus_read(8'h91, rd);
    check("postrst_rd91", {24'd0, rd}, 32'h89);

`ifdef IR_RX_ERRCNT_EN
    bus_read(8'h92, rd);
    check("errcnt_initial", {24'd0, rd}, 32'h00);
    for (int p = 0; p < 17; p++) begin
      push_ev(1'b1, last_cmd);
      mark(30);
      space(10);
    end
    check("errcnt_pending", exp_q.size(), 32'd0);
    bus_read(8'h92, rd);
    check("errcnt_sat", {24'd0, rd}, 32'h0F);
    bus_read(8'h92, rd);
    check("errcnt_clear", {24'd0, rd}, 32'h00);
`else
    for (int p = 0; p < 3; p++) begin
      push_ev(1'b1, last_cmd);
      mark(30);
      space(10);
    end
    check("noerrcnt_pending", exp_q.size(), 32'd0);
    bus_read(8'h92, rd);
    check("noerrcnt_rd92", {24'd0, rd}, 32'h00);
`endif

    cyc(10);
    check("final_pending", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
